// File: rtl/hamming_pkg.sv
// Layout shared by the Hamming(38,32) SEC encoder and decoder.
// Every consumer imports this package, so both ends agree on which codeword position carries which bit.
package hamming_pkg;

  localparam int CW_W   = 38;
  localparam int DATA_W = 32;
  localparam int PAR_W  = 6;

  localparam int PAR_POS [PAR_W] = '{1, 2, 4, 8, 16, 32};

  // Codeword position (1-based) of data bit idx.
  // The non-parity positions are filled in ascending order.
  function automatic int data_pos(input int idx);
    int n;
    bit is_par;
    n = 0;
    data_pos = 0;
    for (int p = 1; p <= CW_W; p++) begin
      is_par = 1'b0;
      for (int k = 0; k < PAR_W; k++)
        if (PAR_POS[k] == p) is_par = 1'b1;
      if (!is_par) begin
        if (n == idx) data_pos = p;
        n++;
      end
    end
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome of a 38-bit even-parity Hamming codeword.
// The syndrome is the XOR of the 1-based positions of all set bits.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]  cw_i,
  output logic [PAR_W-1:0] syn_o
);

  always_comb begin
    syn_o = '0;
    for (int p = 1; p <= CW_W; p++)
      if (cw_i[p-1]) syn_o = syn_o ^ PAR_W'(p);
  end

endmodule

// File: rtl/decoder.sv
// Registered Hamming(38,32) SEC decoder: syndrome, single-bit correction, payload extraction.
// Latency is one cycle; the data outputs hold their values while no codeword is presented.
module decoder
  import hamming_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [CW_W-1:0]   data_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] org_data,
  output logic              error,
  output logic              uncorrectable,
  output logic [PAR_W-1:0]  syndrome
);

  logic [PAR_W-1:0]  syn;
  logic [CW_W-1:0]   corrected;
  logic [DATA_W-1:0] data_d, data_q;
  logic              err_d, err_q;
  logic              unc_d, unc_q;
  logic [PAR_W-1:0]  syn_q;
  logic              valid_q;

  hamming_syndrome u_syndrome (
    .cw_i  (data_in),
    .syn_o (syn)
  );

  // A syndrome above CW_W matches no position, so it leaves the word untouched.
  always_comb begin
    corrected = data_in;
    for (int p = 1; p <= CW_W; p++)
      if (syn == PAR_W'(p)) corrected[p-1] = ~corrected[p-1];
  end

  always_comb begin
    data_d = '0;
    for (int i = 0; i < DATA_W; i++)
      data_d[i] = corrected[data_pos(i)-1];
    err_d = (syn != '0);
    unc_d = (syn > PAR_W'(CW_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      unc_q   <= 1'b0;
      syn_q   <= '0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) begin
        data_q <= data_d;
        err_q  <= err_d;
        unc_q  <= unc_d;
        syn_q  <= syn;
      end
    end
  end

  assign valid_out     = valid_q;
  assign org_data      = data_q;
  assign error         = err_q;
  assign uncorrectable = unc_q;
  assign syndrome      = syn_q;

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for the Hamming(38,32) decoder, driven by directed vectors.
// The driver queues the expected result for each codeword it sends; the monitor pops and compares it when valid_out rises.
module tb_decoder;

  typedef struct packed {
    logic [37:0] cw;
    logic [31:0] data;
    logic        err;
    logic        unc;
    logic [5:0]  syn;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [37:0] data_in;
  logic        valid_out;
  logic [31:0] org_data;
  logic        error;
  logic        uncorrectable;
  logic [5:0]  syndrome;

  int checks = 0;
  int errors = 0;
  vec_t exp_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  decoder dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .valid_out     (valid_out),
    .org_data      (org_data),
    .error         (error),
    .uncorrectable (uncorrectable),
    .syndrome      (syndrome)
  );

  task automatic check_outs(input string name, input logic vo, input logic [31:0] d,
                            input logic e, input logic u, input logic [5:0] s);
    checks++;
    if (valid_out !== vo || org_data !== d || error !== e || uncorrectable !== u || syndrome !== s) begin
      errors++;
      $display("FAIL %s: got valid=%b data=%h err=%b unc=%b syn=%0d, expected valid=%b data=%h err=%b unc=%b syn=%0d",
               name, valid_out, org_data, error, uncorrectable, syndrome, vo, d, e, u, s);
    end
  endtask

  // Monitor: one comparison per presented result.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got valid_out=1 data=%h, expected no pending codeword", org_data);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        check_outs($sformatf("cw_%h", e.cw), 1'b1, e.data, e.err, e.unc, e.syn);
      end
    end
  end

  task automatic send(input vec_t v);
    @(negedge clk);
    rst      = 1'b0;
    valid_in = 1'b1;
    data_in  = v.cw;
    exp_q.push_back(v);
  endtask

  initial begin
    // cw, data, err, unc, syndrome
    vecs.push_back({38'h00_0000_0000, 32'h0000_0000, 1'b0, 1'b0, 6'd0});
    vecs.push_back({38'h00_0000_0007, 32'h0000_0001, 1'b0, 1'b0, 6'd0});
    vecs.push_back({38'h20_0000_0007, 32'h0000_0001, 1'b1, 1'b0, 6'd38});
    vecs.push_back({38'h00_0000_0001, 32'h0000_0000, 1'b1, 1'b0, 6'd1});
    vecs.push_back({38'h00_8000_0040, 32'h0000_0008, 1'b1, 1'b1, 6'd39});
    vecs.push_back({38'h20_8000_000A, 32'h8000_0000, 1'b0, 1'b0, 6'd0});
    vecs.push_back({38'h20_8008_000A, 32'h8000_0000, 1'b1, 1'b0, 6'd20});
    vecs.push_back({38'h00_0000_0040, 32'h0000_0000, 1'b1, 1'b0, 6'd7});
    vecs.push_back({38'h00_C000_0000, 32'h0200_0000, 1'b1, 1'b1, 6'd63});
    // Double error on the data-1 codeword (positions 1 and 2) miscorrects position 3.
    vecs.push_back({38'h00_0000_0004, 32'h0000_0000, 1'b1, 1'b0, 6'd3});

    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk);
    check_outs("reset_state", 1'b0, 32'h0, 1'b0, 1'b0, 6'd0);

    foreach (vecs[i]) send(vecs[i]);

    // Idle cycle: valid drops, data outputs keep the last result.
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = 38'h3F_FFFF_FFFF;
    @(negedge clk);
    check_outs("hold_after_idle", 1'b0, 32'h0, 1'b1, 1'b0, 6'd3);

    send(vecs[4]);
    // Reset with valid high discards this codeword.
    @(negedge clk);
    rst      = 1'b1;
    valid_in = 1'b1;
    data_in  = 38'h20_0000_0007;
    @(negedge clk);
    check_outs("reset_with_valid", 1'b0, 32'h0, 1'b0, 1'b0, 6'd0);
    rst      = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    check_outs("idle_after_reset", 1'b0, 32'h0, 1'b0, 1'b0, 6'd0);

    send(vecs[2]);
    send(vecs[8]);
    @(negedge clk);
    valid_in = 1'b0;

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d results still pending, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
